// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath constants: ALU status bit positions, branch type
// encodings, B.cond condition codes and the branch-result FSM states.
package legv8_pkg;

  // Status / flag vector layout is {V, C, N, Z}.
  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_C = 2;
  localparam int ST_V = 3;

  typedef enum logic [1:0] {
    BR_B    = 2'b00,
    BR_COND = 2'b01,
    BR_CBZ  = 2'b10,
    BR_CBNZ = 2'b11
  } br_type_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'b0000,
    CC_NE = 4'b0001,
    CC_HS = 4'b0010,
    CC_LO = 4'b0011,
    CC_MI = 4'b0100,
    CC_PL = 4'b0101,
    CC_VS = 4'b0110,
    CC_VC = 4'b0111,
    CC_HI = 4'b1000,
    CC_LS = 4'b1001,
    CC_GE = 4'b1010,
    CC_LT = 4'b1011,
    CC_GT = 4'b1100,
    CC_LE = 4'b1101,
    CC_AL = 4'b1110,
    CC_NV = 4'b1111
  } cond_e;

  typedef enum logic [0:0] {
    BR_IDLE     = 1'b0,
    BR_RESOLVED = 1'b1
  } br_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational B.cond condition table over a {V, C, N, Z} flag vector.
// Kept standalone so a conditional-select unit can reuse it.
module cond_eval
  import legv8_pkg::*;
#(
  parameter int COND_W = 4
) (
  input  logic [COND_W-1:0] cond,
  input  logic [3:0]        flags,
  output logic              pass
);

  logic z, n, c, v;

  assign z = flags[ST_Z];
  assign n = flags[ST_N];
  assign c = flags[ST_C];
  assign v = flags[ST_V];

  always_comb begin
    pass = 1'b0;
    case (cond[3:0])
      CC_EQ: pass = z;
      CC_NE: pass = ~z;
      CC_HS: pass = c;
      CC_LO: pass = ~c;
      CC_MI: pass = n;
      CC_PL: pass = ~n;
      CC_VS: pass = v;
      CC_VC: pass = ~v;
      CC_HI: pass = c & ~z;
      CC_LS: pass = ~(c & ~z);
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = ~z & (n == v);
      CC_LE: pass = ~(~z & (n == v));
      // NV behaves as AL in this ISA.
      CC_AL: pass = 1'b1;
      CC_NV: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_branch_unit.sv
// NZCV flag register plus B / B.cond / CBZ / CBNZ resolver with a registered
// taken result one cycle after each request.
//
// Handshake: valid-only, no backpressure. A request is accepted in any cycle
// with br_valid=1 and flush=0; its result appears on taken with taken_valid=1
// for exactly the following cycle and must be consumed then.
module cond_branch_unit
  import legv8_pkg::*;
#(
  parameter int COND_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        status,
  input  logic              set_flags,
  input  logic              br_valid,
  input  logic [1:0]        br_type,
  input  logic [COND_W-1:0] cond,
  input  logic              flush,
  output logic [3:0]        flags_q,
  output logic              taken,
  output logic              taken_valid,
  output logic              state_dbg
);

  br_state_e state_q, state_d;
  logic [3:0] eff_flags;
  logic       cond_pass;
  logic       decision;
  logic       load_taken;

  // A flag-setting instruction in the same cycle forwards its live status.
  assign eff_flags = set_flags ? status : flags_q;

  cond_eval #(.COND_W(COND_W)) u_cond_eval (
    .cond  (cond),
    .flags (eff_flags),
    .pass  (cond_pass)
  );

  // CBZ/CBNZ use live status: the ALU passes Rt through, so Z means Rt==0.
  always_comb begin
    decision = 1'b0;
    case (br_type)
      BR_B:    decision = 1'b1;
      BR_COND: decision = cond_pass;
      BR_CBZ:  decision = status[ST_Z];
      BR_CBNZ: decision = ~status[ST_Z];
      default: decision = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= 4'b0000;
    end else if (set_flags) begin
      flags_q <= status;
    end
  end

  always_comb begin
    state_d    = BR_IDLE;
    load_taken = 1'b0;
    case (state_q)
      BR_IDLE: begin
        if (br_valid && !flush) begin
          state_d    = BR_RESOLVED;
          load_taken = 1'b1;
        end
      end
      BR_RESOLVED: begin
        // Back-to-back requests keep the FSM here, one result per cycle.
        if (br_valid && !flush) begin
          state_d    = BR_RESOLVED;
          load_taken = 1'b1;
        end
      end
      default: begin
        state_d    = BR_IDLE;
        load_taken = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken <= 1'b0;
    end else if (load_taken) begin
      taken <= decision;
    end
  end

  assign taken_valid = (state_q == BR_RESOLVED);
  assign state_dbg   = state_q;

endmodule
